// File: rtl/resource_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// resource_arbiter_pkg
// Shared types and constants for the resource arbiter and related shared-port
// arbiters.
//   arb_state_t           : 2-bit arbiter state encoding
//   RES_ARB_TIMEOUT_WIDTH : width of the WAIT watchdog counter
//   RES_ARB_MAX_REQ       : largest supported requester count
//   idx_width()           : index width for n requesters (never below 1)
// -----------------------------------------------------------------------------
package resource_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_t;

    localparam int RES_ARB_TIMEOUT_WIDTH = 8;
    localparam int RES_ARB_MAX_REQ       = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resource_arbiter_if.sv
// -----------------------------------------------------------------------------
// resource_arbiter_if
// Bundles the requester-side and back-end-side signals of the resource
// arbiter.
//   requester side : read_req, write_req, handle_in, arg_a_in, arg_b_in (to
//                    arbiter); read_valid, write_ack, data_out (from arbiter)
//   back-end side  : mem_req, mem_write, mem_handle, mem_arg_a, mem_arg_b
//                    (from arbiter); mem_ready, mem_done, mem_rdata (to arbiter)
// Modports: master = arbiter, slave = requesters plus memory/LUT controller.
// -----------------------------------------------------------------------------
interface resource_arbiter_if #(
    parameter int data_width   = 16,
    parameter int handle_width = 8,
    parameter int n_req        = 4
);
    logic [n_req-1:0]              read_req;
    logic [n_req-1:0]              write_req;
    logic [n_req*handle_width-1:0] handle_in;
    logic [n_req*data_width-1:0]   arg_a_in;
    logic [n_req*data_width-1:0]   arg_b_in;
    logic [n_req-1:0]              read_valid;
    logic [n_req-1:0]              write_ack;
    logic [data_width-1:0]         data_out;

    logic                          mem_req;
    logic                          mem_write;
    logic [handle_width-1:0]       mem_handle;
    logic [data_width-1:0]         mem_arg_a;
    logic [data_width-1:0]         mem_arg_b;
    logic                          mem_ready;
    logic                          mem_done;
    logic [data_width-1:0]         mem_rdata;

    modport master (
        input  read_req, write_req, handle_in, arg_a_in, arg_b_in,
               mem_ready, mem_done, mem_rdata,
        output read_valid, write_ack, data_out,
               mem_req, mem_write, mem_handle, mem_arg_a, mem_arg_b
    );

    modport slave (
        output read_req, write_req, handle_in, arg_a_in, arg_b_in,
               mem_ready, mem_done, mem_rdata,
        input  read_valid, write_ack, data_out,
               mem_req, mem_write, mem_handle, mem_arg_a, mem_arg_b
    );
endinterface

// File: rtl/resource_arbiter_rr_grant_pick.sv
// -----------------------------------------------------------------------------
// rr_grant_pick
// Combinational round-robin pick: returns the first active index found when
// scanning upward from i_ptr, wrapping modulo n_req.
//   i_active : per-requester active vector
//   i_ptr    : scan start index (must be < n_req)
//   o_found  : at least one requester is active
//   o_idx    : chosen index (0 when nothing is active)
// -----------------------------------------------------------------------------
module rr_grant_pick
    import resource_arbiter_pkg::*;
#(
    parameter  int n_req = 4,
    localparam int IW    = idx_width(n_req)
) (
    input  logic [n_req-1:0] i_active,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);
    int w_dist;
    int w_best;

    // Smallest forward distance from the pointer wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = n_req;
        w_dist  = 0;
        for (int j = 0; j < n_req; j++) begin
            w_dist = (j + n_req - int'(i_ptr)) % n_req;
            if (i_active[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/resource_arbiter.sv
// -----------------------------------------------------------------------------
// resource_arbiter
// Shares one back-end resource port among n_req requesters, round-robin, with
// a single outstanding transaction.
//   clk, reset (async, active-low), enable (permits new grants)
//   bus         : resource_arbiter_if.master (requester and back-end signals)
//   grant_idx   : index of the current/last grant
//   busy        : arbiter not idle
//   timeout_err : sticky WAIT watchdog flag
// Optional feature macro: RES_ARB_TIMEOUT_EN (WAIT watchdog of timeout_cycles).
//
// state     | meaning
// ARB_IDLE  | waiting for an active request while enable is high
// ARB_ISSUE | mem_req held with latched fields until mem_ready
// ARB_WAIT  | request accepted, waiting for mem_done (or watchdog)
// ARB_RESP  | one-cycle read_valid/write_ack to the granted requester
// -----------------------------------------------------------------------------
module resource_arbiter
    import resource_arbiter_pkg::*;
#(
    parameter  int data_width     = 16,
    parameter  int handle_width   = 8,
    parameter  int n_req          = 4,
    parameter  int timeout_cycles = 255,
    localparam int IW             = idx_width(n_req)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    resource_arbiter_if.master   bus,
    output logic [IW-1:0]        grant_idx,
    output logic                 busy,
    output logic                 timeout_err
);
    arb_state_t              r_state;
    arb_state_t              w_next;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_grant;
    logic                    r_write;
    logic [handle_width-1:0] r_handle;
    logic [data_width-1:0]   r_arg_a;
    logic [data_width-1:0]   r_arg_b;
    logic [data_width-1:0]   r_data;
    logic [n_req-1:0]        w_active;
    logic [n_req-1:0]        w_sel;
    logic                    w_found;
    logic [IW-1:0]           w_pick;
    logic                    w_tmo;

    assign w_active = bus.read_req | bus.write_req;

    rr_grant_pick #(.n_req(n_req)) u_pick (
        .i_active (w_active),
        .i_ptr    (r_ptr),
        .o_found  (w_found),
        .o_idx    (w_pick)
    );

`ifdef RES_ARB_TIMEOUT_EN
    logic [RES_ARB_TIMEOUT_WIDTH-1:0] r_wait_cnt;
    logic                             r_tmo_err;

    // Fires on the last of timeout_cycles WAIT cycles; mem_done that same
    // cycle takes priority and completes normally.
    assign w_tmo = (r_state == ARB_WAIT) && !bus.mem_done &&
                   (r_wait_cnt == RES_ARB_TIMEOUT_WIDTH'(timeout_cycles - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_tmo_err  <= 1'b0;
        end else begin
            if (r_state == ARB_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == ARB_WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_tmo)
                r_tmo_err <= 1'b1;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  if (enable && w_found)         w_next = ARB_ISSUE;
            ARB_ISSUE: if (bus.mem_ready)             w_next = ARB_WAIT;
            ARB_WAIT:  if (bus.mem_done || w_tmo)     w_next = ARB_RESP;
            ARB_RESP:                                 w_next = ARB_IDLE;
            default:                                  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_grant  <= '0;
            r_write  <= 1'b0;
            r_handle <= '0;
            r_arg_a  <= '0;
            r_arg_b  <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (enable && w_found) begin
                        r_grant  <= w_pick;
                        r_write  <= bus.write_req[w_pick];
                        r_handle <= bus.handle_in[w_pick*handle_width +: handle_width];
                        r_arg_a  <= bus.arg_a_in[w_pick*data_width +: data_width];
                        r_arg_b  <= bus.arg_b_in[w_pick*data_width +: data_width];
                    end
                end
                ARB_WAIT: begin
                    if (bus.mem_done) begin
                        if (!r_write)
                            r_data <= bus.mem_rdata;
                    end else if (w_tmo && !r_write) begin
                        r_data <= '0;
                    end
                end
                ARB_RESP: begin
                    r_ptr <= (r_grant == IW'(n_req - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < n_req; i++)
            w_sel[i] = (r_grant == IW'(i));
    end

    // Everything below decodes from reset-cleared registers, so asserting
    // reset drops mem_req and the response pulses without a clock edge.
    assign bus.read_valid = ((r_state == ARB_RESP) && !r_write) ? w_sel : '0;
    assign bus.write_ack  = ((r_state == ARB_RESP) &&  r_write) ? w_sel : '0;
    assign bus.data_out   = r_data;
    assign bus.mem_req    = (r_state == ARB_ISSUE);
    assign bus.mem_write  = r_write;
    assign bus.mem_handle = r_handle;
    assign bus.mem_arg_a  = r_arg_a;
    assign bus.mem_arg_b  = r_arg_b;
    assign grant_idx      = r_grant;
    assign busy           = (r_state != ARB_IDLE);
endmodule

// File: tb/tb_resource_arbiter.sv
module tb_resource_arbiter;
    localparam int DW = 16;
    localparam int HW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout_err;

    resource_arbiter_if #(.data_width(DW), .handle_width(HW), .n_req(N)) bus ();

    resource_arbiter #(
        .data_width(DW), .handle_width(HW), .n_req(N), .timeout_cycles(8)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .enable      (enable),
        .bus         (bus.master),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- requester state ----------------
    logic          rq_rd [N];
    logic          rq_wr [N];
    logic [HW-1:0] rq_h  [N];
    logic [DW-1:0] rq_a  [N];
    logic [DW-1:0] rq_b  [N];

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.read_req[i]             = rq_rd[i];
            bus.write_req[i]            = rq_wr[i];
            bus.handle_in[i*HW +: HW]   = rq_h[i];
            bus.arg_a_in[i*DW +: DW]    = rq_a[i];
            bus.arg_b_in[i*DW +: DW]    = rq_b[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            rq_rd[i] = 1'b0; rq_wr[i] = 1'b0;
            rq_h[i] = '0; rq_a[i] = '0; rq_b[i] = '0;
        end
        drive_reqs();
    endtask

    task automatic set_req(input int r, input logic rd, input logic wr,
                           input logic [HW-1:0] h, input logic [DW-1:0] a, input logic [DW-1:0] b);
        rq_rd[r] = rd; rq_wr[r] = wr; rq_h[r] = h; rq_a[r] = a; rq_b[r] = b;
    endtask

    // ---------------- back-end model ----------------
    int            be_phase = 0;
    int            be_cnt = 0;
    int            be_rl = 0;
    int            be_dl = 0;
    bit            be_hang = 0;
    bit            be_abort = 0;
    bit            be_random = 0;
    int            be_issue_cyc = 0;
    int            be_unstable = 0;
    logic [DW-1:0] be_rdata_next = '0;
    logic          cap_write;
    logic [HW-1:0] cap_h;
    logic [DW-1:0] cap_a, cap_b, cap_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            be_phase = 0;
            bus.mem_ready = 1'b0;
            bus.mem_done  = 1'b0;
        end else begin
            bus.mem_done = 1'b0;
            if (be_phase == 0 && bus.mem_req) begin
                be_phase = 1; be_cnt = 0; be_issue_cyc = 0;
                cap_write = bus.mem_write; cap_h = bus.mem_handle;
                cap_a = bus.mem_arg_a; cap_b = bus.mem_arg_b;
                if (be_random) begin
                    be_rl = $urandom_range(0, 3);
                    be_dl = $urandom_range(0, 3);
                end
            end
            if (be_phase == 1) begin
                if (bus.mem_ready) begin
                    bus.mem_ready = 1'b0; be_phase = 2; be_cnt = 0;
                end else begin
                    be_issue_cyc++;
                    if (!bus.mem_req || bus.mem_write !== cap_write || bus.mem_handle !== cap_h ||
                        bus.mem_arg_a !== cap_a || bus.mem_arg_b !== cap_b)
                        be_unstable++;
                    if (be_cnt >= be_rl) bus.mem_ready = 1'b1;
                    else be_cnt++;
                end
            end
            if (be_phase == 2) begin
                if (be_abort) begin
                    be_phase = 0; be_abort = 0;
                end else if (!be_hang && be_cnt >= be_dl) begin
                    cap_rdata = be_random ? DW'($urandom) : be_rdata_next;
                    bus.mem_rdata = cap_rdata;
                    bus.mem_done  = 1'b1;
                    be_phase = 0;
                end else begin
                    be_cnt++;
                end
            end
        end
    end

    // Waits for a response pulse; cyc = maxc+1 when none arrived.
    task automatic wait_pulse(input int maxc, output int cyc,
                              output logic [N-1:0] rv, output logic [N-1:0] wa);
        rv = '0; wa = '0;
        for (cyc = 1; cyc <= maxc; cyc++) begin
            @(negedge clk);
            if (|(bus.read_valid | bus.write_ack)) begin
                rv = bus.read_valid; wa = bus.write_ack;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int            r;
        logic          rd, wr;
        logic [HW-1:0] h;
        logic [DW-1:0] a, b;
        int            rl, dl;
        logic [DW-1:0] rdata;
        logic [N-1:0]  exp_rv, exp_wa;
        logic [DW-1:0] exp_data;
        int            exp_cyc;
    } vec_t;

    vec_t vt [5];

    initial begin
        int            cyc;
        logic [N-1:0]  rv, wa;
        int            viol;
        int            order [4];
        logic [N-1:0]  pend_drv;
        int            mptr, cur_g, exp_g, just;
        bit            cur_w, prev_req;
        logic [DW-1:0] mdata;
        int            waits [N];

        vt[0] = '{0, 1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 4'b0001, 4'b0000, 16'hBEEF, 3};
        vt[1] = '{1, 1'b0, 1'b1, 8'h34, 16'h0001, 16'h7FFF, 2, 0, 16'h5555, 4'b0000, 4'b0010, 16'hBEEF, 5};
        vt[2] = '{2, 1'b1, 1'b1, 8'h56, 16'h1111, 16'h2222, 0, 1, 16'h6666, 4'b0000, 4'b0100, 16'hBEEF, 4};
        vt[3] = '{3, 1'b1, 1'b0, 8'hA5, 16'h00AA, 16'h0055, 1, 2, 16'h1234, 4'b1000, 4'b0000, 16'h1234, 6};
        vt[4] = '{0, 1'b1, 1'b0, 8'hFF, 16'hFFFF, 16'hFFFF, 0, 3, 16'h0000, 4'b0001, 4'b0000, 16'h0000, 6};
        order = '{0, 2, 3, 0};

        rst_n = 1'b0;
        enable = 1'b1;
        bus.mem_ready = 1'b0; bus.mem_done = 1'b0; bus.mem_rdata = '0;
        clear_reqs();
        repeat (2) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {bus.read_valid, bus.write_ack}, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table-driven single transactions ----
        for (int v = 0; v < 5; v++) begin
            be_rl = vt[v].rl; be_dl = vt[v].dl; be_rdata_next = vt[v].rdata;
            set_req(vt[v].r, vt[v].rd, vt[v].wr, vt[v].h, vt[v].a, vt[v].b);
            drive_reqs();
            wait_pulse(40, cyc, rv, wa);
            check($sformatf("v%0d_cycles", v), cyc, vt[v].exp_cyc);
            check($sformatf("v%0d_read_valid", v), rv, vt[v].exp_rv);
            check($sformatf("v%0d_write_ack", v), wa, vt[v].exp_wa);
            check($sformatf("v%0d_data_out", v), bus.data_out, vt[v].exp_data);
            check($sformatf("v%0d_mem_handle", v), cap_h, vt[v].h);
            check($sformatf("v%0d_mem_args", v), {cap_a, cap_b}, {vt[v].a, vt[v].b});
            check($sformatf("v%0d_mem_write", v), cap_write, vt[v].wr);
            check($sformatf("v%0d_issue_cycles", v), be_issue_cyc, vt[v].rl + 1);
            check($sformatf("v%0d_grant_idx", v), grant_idx, vt[v].r);
            clear_reqs();
            @(negedge clk);
            check($sformatf("v%0d_idle_after", v), {busy, bus.read_valid, bus.write_ack}, 0);
            @(negedge clk);
            check($sformatf("v%0d_no_regrant", v), {busy, bus.mem_req}, 0);
        end

        // ---- reset during WAIT ----
        be_hang = 1; be_rl = 0;
        set_req(1, 1'b1, 1'b0, 8'h77, 16'h0101, 16'h0202);
        drive_reqs();
        viol = 1;
        for (int k = 0; k < 20 && viol != 0; k++) begin
            @(negedge clk);
            if (busy && !bus.mem_req && be_phase == 2) viol = 0;
        end
        check("wait_reached", viol, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", bus.mem_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_pulses", {bus.read_valid, bus.write_ack}, 0);
        check("async_rst_grant_idx", grant_idx, 0);
        clear_reqs();
        be_hang = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        // ---- contention 0,2,3 from ptr 0 ----
        be_rl = 0; be_dl = 0; be_rdata_next = 16'h0ABC;
        set_req(0, 1'b1, 1'b0, 8'h10, 16'h0, 16'h0);
        set_req(2, 1'b0, 1'b1, 8'h20, 16'h2, 16'h2);
        set_req(3, 1'b1, 1'b0, 8'h30, 16'h3, 16'h3);
        drive_reqs();
        for (int k = 0; k < 4; k++) begin
            int g;
            wait_pulse(30, cyc, rv, wa);
            check($sformatf("cont%0d_pulse", k), rv | wa, N'(1) << order[k]);
            g = -1;
            for (int i = 0; i < N; i++) if ((rv | wa) == (N'(1) << i)) g = i;
            if (k == 3) begin
                clear_reqs();
            end else if (g >= 0) begin
                logic sv_rd, sv_wr;
                sv_rd = rq_rd[g]; sv_wr = rq_wr[g];
                rq_rd[g] = 1'b0; rq_wr[g] = 1'b0;
                drive_reqs();
                @(negedge clk);
                rq_rd[g] = sv_rd; rq_wr[g] = sv_wr;
                drive_reqs();
            end
        end
        check("cont_data_out", bus.data_out, 16'h0ABC);
        repeat (3) @(negedge clk);
        check("cont_idle", busy, 0);

        // ---- enable low blocks new grants ----
        enable = 1'b0;
        set_req(2, 1'b0, 1'b1, 8'h42, 16'h4242, 16'h2424);
        drive_reqs();
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_req || busy) viol++;
        end
        check("enable_low_no_grant", viol, 0);
        enable = 1'b1;
        @(negedge clk);
        check("enable_grant_mem_req", bus.mem_req, 1);
        check("enable_grant_idx", grant_idx, 2);
        wait_pulse(30, cyc, rv, wa);
        check("enable_write_ack", {rv, wa}, {4'b0000, 4'b0100});
        clear_reqs();
        repeat (2) @(negedge clk);

`ifdef RES_ARB_TIMEOUT_EN
        // ---- watchdog ----
        be_hang = 1; be_rl = 0;
        set_req(3, 1'b1, 1'b0, 8'h99, 16'h9, 16'h9);
        drive_reqs();
        wait_pulse(40, cyc, rv, wa);
        check("tmo_cycles", cyc, 10);
        check("tmo_read_valid", rv, 4'b1000);
        check("tmo_data_out", bus.data_out, 0);
        check("tmo_err_set", timeout_err, 1);
        clear_reqs();
        be_hang = 0; be_abort = 1;
        repeat (3) @(negedge clk);
        be_dl = 0; be_rdata_next = 16'h4321;
        set_req(0, 1'b1, 1'b0, 8'h01, 16'h1, 16'h1);
        drive_reqs();
        wait_pulse(30, cyc, rv, wa);
        check("tmo_next_read", {rv, bus.data_out}, {4'b0001, 16'h4321});
        check("tmo_err_sticky", timeout_err, 1);
        clear_reqs();
`endif

        do_reset();
        @(negedge clk);
        check("timeout_err_after_rst", timeout_err, 0);

        // ---- randomized traffic against a round-robin model ----
        be_random = 1;
        pend_drv = '0; mptr = 0; cur_g = -1; cur_w = 0; prev_req = 0; mdata = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            just = -1;
            if (bus.mem_req && !prev_req) begin
                exp_g = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (exp_g < 0 && pend_drv[j]) exp_g = j;
                end
                check("rand_grant_idx", grant_idx, exp_g);
                if (exp_g >= 0) begin
                    check("rand_mem_fields", {bus.mem_write, bus.mem_handle, bus.mem_arg_a, bus.mem_arg_b},
                          {rq_wr[exp_g], rq_h[exp_g], rq_a[exp_g], rq_b[exp_g]});
                    cur_w = rq_wr[exp_g];
                end
                cur_g = exp_g;
            end
            prev_req = bus.mem_req;
            if (|(bus.read_valid | bus.write_ack)) begin
                if (cur_g < 0) begin
                    check("rand_spurious_pulse", {bus.read_valid, bus.write_ack}, 0);
                end else begin
                    check("rand_pulse", {bus.read_valid, bus.write_ack},
                          cur_w ? {4'b0000, N'(1) << cur_g} : {N'(1) << cur_g, 4'b0000});
                    if (!cur_w) mdata = cap_rdata;
                    check("rand_data_out", bus.data_out, mdata);
                    for (int i = 0; i < N; i++)
                        if (i != cur_g && (rq_rd[i] || rq_wr[i])) waits[i]++;
                    check("rand_fairness", waits[cur_g] <= N - 1, 1);
                    waits[cur_g] = 0;
                    mptr = (cur_g + 1) % N;
                    rq_rd[cur_g] = 1'b0; rq_wr[cur_g] = 1'b0;
                    just = cur_g;
                    cur_g = -1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!rq_rd[i] && !rq_wr[i] && i != just && c < 3800 &&
                    $urandom_range(0, 99) < 30) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    set_req(i, kind != 1, kind != 0, HW'($urandom), DW'($urandom), DW'($urandom));
                    waits[i] = 0;
                end
            end
            drive_reqs();
            for (int i = 0; i < N; i++) pend_drv[i] = rq_rd[i] | rq_wr[i];
        end
        check("rand_drained", {pend_drv, busy}, 0);
        check("mem_fields_stable", be_unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
